// File: rtl/alu_issue_stage.sv
// Operand-fetch / writeback stage around a combinational ALU: owns the 16x16 register
// file, forwards the in-flight EX result, and reports each commit on a one-cycle strobe.
`ifndef ALU_MODE_LEN
`define ALU_MODE_LEN 5
`endif
`ifndef SHIFT_LEN
`define SHIFT_LEN 4
`endif
`ifndef REG_WORD_LEN
`define REG_WORD_LEN 16
`endif
`ifndef ALU_NOP
`define ALU_NOP    5'd0
`define ALU_ADD    5'd1
`define ALU_ADD_I  5'd2
`define ALU_IADD   5'd3
`define ALU_IADD_I 5'd4
`define ALU_SUB    5'd5
`define ALU_SUB_I  5'd6
`define ALU_MAC    5'd7
`define ALU_BEZ    5'd8
`define ALU_BNEZ   5'd9
`endif

module alu_issue_stage #(
  parameter int WORD = `REG_WORD_LEN,
  parameter int OPW  = `ALU_MODE_LEN,
  parameter int SHW  = `SHIFT_LEN,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_opcode,
  input  logic [SHW-1:0]  in_shift,
  input  logic [3:0]      in_rd,
  input  logic [3:0]      in_ra,
  input  logic [3:0]      in_rb,
  input  logic [3:0]      in_rc,
  input  logic [WORD-1:0] in_imm,
  input  logic            in_imm_en,
  input  logic            hold,
  output logic [OPW-1:0]  alu_opcode,
  output logic [SHW-1:0]  alu_shift,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [WORD-1:0] alu_c,
  input  logic [WORD-1:0] alu_y,
  output logic            res_valid,
  output logic [3:0]      res_rd,
  output logic [WORD-1:0] res_data,
  output logic            res_wen,
  output logic            res_branch,
  output logic            res_taken,
  input  logic [3:0]      dbg_addr,
  output logic [WORD-1:0] dbg_data
);

  logic [WORD-1:0] regs [NREG];

  logic            vld_p1;
  logic            wen_p1;
  logic [OPW-1:0]  op_p1;
  logic [SHW-1:0]  sh_p1;
  logic [3:0]      rd_p1;
  logic [WORD-1:0] a_p1, b_p1, c_p1;

  logic            issue, commit;
  logic [WORD-1:0] src_a, src_b, src_c;

  function automatic logic op_is_branch(input logic [OPW-1:0] op);
    return (op == OPW'(`ALU_BEZ)) || (op == OPW'(`ALU_BNEZ));
  endfunction

  function automatic logic op_writes(input logic [OPW-1:0] op);
    return !((op == OPW'(`ALU_NOP)) || op_is_branch(op));
  endfunction

  // R0 is hardwired zero; otherwise the EX result wins over the (not yet written) file.
  function automatic logic [WORD-1:0] pick_src(input logic [3:0] r, input logic [WORD-1:0] rf,
                                               input logic hit, input logic [WORD-1:0] fwd);
    if (r == 4'd0) return '0;
    if (hit) return fwd;
    return rf;
  endfunction

  assign in_ready = ~hold & ~rst;
  assign issue    = in_valid & in_ready;
  assign commit   = vld_p1 & ~hold;

  assign src_a = pick_src(in_ra, regs[in_ra], vld_p1 & wen_p1 & (rd_p1 == in_ra), alu_y);
  assign src_b = pick_src(in_rb, regs[in_rb], vld_p1 & wen_p1 & (rd_p1 == in_rb), alu_y);
  assign src_c = pick_src(in_rc, regs[in_rc], vld_p1 & wen_p1 & (rd_p1 == in_rc), alu_y);

  assign alu_opcode = op_p1;
  assign alu_shift  = sh_p1;
  assign alu_a      = a_p1;
  assign alu_b      = b_p1;
  assign alu_c      = c_p1;

  assign dbg_data = (dbg_addr == 4'd0) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      vld_p1     <= 1'b0;
      wen_p1     <= 1'b0;
      op_p1      <= '0;
      sh_p1      <= '0;
      rd_p1      <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      c_p1       <= '0;
      res_valid  <= 1'b0;
      res_rd     <= '0;
      res_data   <= '0;
      res_wen    <= 1'b0;
      res_branch <= 1'b0;
      res_taken  <= 1'b0;
    end else begin
      // writeback / commit boundary: EX result lands in the file and on res_*
      res_valid <= commit;
      if (commit) begin
        if (wen_p1 && rd_p1 != 4'd0) regs[rd_p1] <= alu_y;
        res_rd     <= rd_p1;
        res_data   <= alu_y;
        res_wen    <= wen_p1 & (rd_p1 != 4'd0);
        res_branch <= op_is_branch(op_p1);
        res_taken  <= op_is_branch(op_p1) & (alu_y == '0);
      end
      // issue boundary: operands fetched (with forwarding) into EX
      if (!hold) begin
        vld_p1 <= issue;
        if (issue) begin
          wen_p1 <= op_writes(in_opcode);
          op_p1  <= in_opcode;
          sh_p1  <= in_shift;
          rd_p1  <= in_rd;
          a_p1   <= src_a;
          b_p1   <= in_imm_en ? in_imm : src_b;
          c_p1   <= src_c;
        end
      end
    end
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

- Single-issue operand-fetch and writeback stage wrapped around the combinational ALU.
- Upstream: accepts decoded instructions over a valid/ready handshake.
- Owns a 16-entry × 16-bit register file and reads operands from it, with a forward path from the instruction currently in EX.
- Drives registered operands into the ALU; on the following edge, commits the ALU result to the register file and reports it on a one-cycle result strobe, including branch outcome for BEZ/BNEZ.

## Interface
- `WORD`, 16: datapath width; equals `` `REG_WORD_LEN``.
- `OPW`, `` `ALU_MODE_LEN``: opcode width.
- `SHW`, `` `SHIFT_LEN``: shift-amount width.
- `NREG`, 16: register count; register addresses are 4 bits.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage accepts. Equals `~hold & ~rst`.
- `in_opcode` in OPW: ALU opcode (`` `ALU_* `` encodings).
- `in_shift` in SHW: shift amount.
- `in_rd`, `in_ra`, `in_rb`, `in_rc` in 4 each: destination and source registers.
- `in_imm` in WORD: immediate value.
- `in_imm_en` in 1: B operand = `in_imm` instead of `R[rb]`.
- `hold` in 1: freeze the whole stage.
- `alu_opcode` out OPW, `alu_shift` out SHW, `alu_a` / `alu_b` / `alu_c` out WORD: registered EX operands to the ALU.
- `alu_y` in WORD: combinational ALU result.
- `res_valid` out 1: one-cycle commit strobe.
- `res_rd` out 4: committed destination register.
- `res_data` out WORD: committed value.
- `res_wen` out 1: register file was written.
- `res_branch` out 1: committed op was BEZ/BNEZ.
- `res_taken` out 1: branch taken.
- `dbg_addr` in 4, `dbg_data` out WORD: combinational register-file read port for test. No forwarding on this port.

## Operation
- **Issue:** an instruction is accepted on an edge where `in_valid & in_ready`. At that edge the EX registers load:
  - `ex_valid` = 1
  - opcode, shift and rd
  - `ex_a` = src(ra)
  - `ex_b` = `in_imm_en` ? `in_imm` : src(rb)
  - `ex_c` = src(rc)
- **src(r) priority, evaluated in the issue cycle:**
  1. r == 0 → 0.
  2. `ex_valid & ex_wen & ex_rd == r` → `alu_y` (EX forward).
  3. Otherwise `R[r]`.
- **Write enable:** `ex_wen` = 0 for `` `ALU_NOP``, `` `ALU_BEZ`` and `` `ALU_BNEZ``; 1 for all other opcodes.
- **ALU drive:** `alu_*` outputs are driven directly from the EX registers.
- **Commit:** happens at every edge with `ex_valid & ~hold`.
  - `R[ex_rd] <= alu_y` if `ex_wen` and `ex_rd != 0`.
  - `res_valid <= 1`, `res_rd <= ex_rd`, `res_data <= alu_y`, `res_wen <= ex_wen & (ex_rd != 0)`.
  - `res_branch <= (opcode is BEZ or BNEZ)`.
  - `res_taken <= res_branch_next & (alu_y == 0)`. The ALU returns 0 for BEZ when A==0 and for BNEZ when A!=0, so "taken" is always `alu_y == 0`.
- **Empty EX:** if no instruction is issued on a commit edge, `ex_valid <= 0`. `res_valid` is 0 on any edge without a commit.
- **Back-to-back:** issue and commit happen on the same edge. The new instruction's forward path sees the committing result via `alu_y`, so there is no bubble.
- **R0:** reads as 0; writes to it are discarded.
- **Hold:**
  - EX registers, register file, and `alu_*` outputs are frozen.
  - No issue, since `in_ready` = 0.
  - `res_valid` = 0.
  - When `hold` drops, the held EX instruction commits on the next edge.
- **Reset:**
  - At an edge with `rst` = 1, all R[0..15] = 0, `ex_valid` = 0, EX operand/opcode registers = 0, all `res_*` = 0.
  - An in-flight EX instruction is dropped with no write.
  - `rst` overrides `hold` and issue.

## Timing
- **Latency:** instruction accepted at edge N is presented to the ALU during cycle N→N+1. Its result is in `R` and on `res_*` after edge N+1.
- **Throughput:** one instruction per cycle while `hold` = 0.
- **Output reset values:** `in_ready` = 0 during `rst`; all `alu_*` = 0; all `res_*` = 0; `dbg_data` = 0.
- **Handshake:**
  - `in_ready` is combinational from `hold`/`rst` only, never from `in_valid`.
  - Upstream must hold its fields stable while `in_valid & ~in_ready`.
- **Combinational paths:**
  - The `alu_y` → `ex_a/b/c` forward path is the only combinational path from input to state through the ALU. It is a single ALU delay plus a 3:1 mux.
  - `dbg_data` is combinational from `dbg_addr`.

## Test plan
- **Reset & R0:** assert `rst` 2 cycles mid-stream with an instruction in EX.
  - → `res_valid` stays 0 and `dbg_data` = 0 for all 16 addresses.
  - Then issue ADD_I rd=0, ra=0, imm=5 → `res_wen` = 0 and R0 reads 0.
- **Immediate + latency:** issue IADD_I r1 = r0 + 0x0010 at edge N.
  - → `alu_b` = 0x0010 during N→N+1.
  - → `res_valid` = 1, `res_data` = 0x0010, `res_rd` = 1 after edge N+1.
  - → `dbg_data(1)` = 0x0010.
- **Back-to-back forward:** with r1 = 0x0010, issue IADD_I r2 = r1 + 3, then immediately IADD r3 = r2 + r1 with shift = 0.
  - → `alu_a` for the second op = 0x0013 (forwarded).
  - → r3 = 0x0023.
  - → `res_valid` high on two consecutive cycles.
- **Hold:** assert `hold` for 3 cycles while SUB_I is in EX.
  - → `in_ready` = 0 and `alu_*` stable throughout.
  - → no `res_valid` during hold.
  - → a single commit on the first edge after `hold` falls.
- **Branches:**
  - BEZ with r4 = 0 → `res_branch` = 1, `res_taken` = 1, `res_wen` = 0.
  - BNEZ with r4 = 0x0007 → `res_taken` = 1.
  - BNEZ with r4 = 0 → `res_taken` = 0.
  - Register file unchanged in all three cases.
- **MAC with C operand:** r5 = 0x4000, r6 = 0x4000, r7 = 0x0000; issue MAC r7 = r5·r6 + r7.
  - → `alu_c` = 0x0000.
  - → `res_data` equals `alu_y` (0x2000 under Q15 scaling).
  - → r7 updated.
